// File: rtl/udp_rx_parser.sv
// UDP receive header extractor: strips the 8-byte UDP header from the first
// payload beat, publishes it with the MAC/IP fields and re-aligns the payload.
module udp_rx_parser #(
    parameter int DATA_W = 128
) (
    input  logic                wClk,
    input  logic                wRst,
    input  logic                wData_Hdr_in_valid,
    output logic                wData_Hdr_in_ready,
    input  logic [47:0]         bData_Hdr_in_MacDstMacAddr,
    input  logic [47:0]         bData_Hdr_in_MacSrcMacAddr,
    input  logic [15:0]         bData_Hdr_in_MacFrameType,
    input  logic [3:0]          bData_Hdr_in_IPVersion,
    input  logic [3:0]          bData_Hdr_in_IPIhl,
    input  logic [5:0]          bData_Hdr_in_IPDscp,
    input  logic [1:0]          bData_Hdr_in_IPEcn,
    input  logic [15:0]         bData_Hdr_in_IPLength,
    input  logic [15:0]         bData_Hdr_in_IPIdentification,
    input  logic [15:0]         bData_Hdr_in_IPCheckSum,
    input  logic [2:0]          bData_Hdr_in_IPFlag,
    input  logic [12:0]         bData_Hdr_in_IPFragOffset,
    input  logic [7:0]          bData_Hdr_in_IPTimeToLive,
    input  logic [7:0]          bData_Hdr_in_IPProtocol,
    input  logic [31:0]         bData_Hdr_in_IPSrcIpAddr,
    input  logic [31:0]         bData_Hdr_in_IPDstIpAddr,
    input  logic                wData_in_valid,
    output logic                wData_in_ready,
    input  logic [DATA_W-1:0]   bData_in_data,
    input  logic [DATA_W/8-1:0] bData_in_keep,
    input  logic                wData_in_last,
    output logic                wData_Hdr_out_valid,
    input  logic                wData_Hdr_out_ready,
    output logic [47:0]         bData_Hdr_out_MacDstMacAddr,
    output logic [47:0]         bData_Hdr_out_MacSrcMacAddr,
    output logic [15:0]         bData_Hdr_out_MacFrameType,
    output logic [3:0]          bData_Hdr_out_IPVersion,
    output logic [3:0]          bData_Hdr_out_IPIhl,
    output logic [5:0]          bData_Hdr_out_IPDscp,
    output logic [1:0]          bData_Hdr_out_IPEcn,
    output logic [15:0]         bData_Hdr_out_IPLength,
    output logic [15:0]         bData_Hdr_out_IPIdentification,
    output logic [15:0]         bData_Hdr_out_IPCheckSum,
    output logic [2:0]          bData_Hdr_out_IPFlag,
    output logic [12:0]         bData_Hdr_out_IPFragOffset,
    output logic [7:0]          bData_Hdr_out_IPTimeToLive,
    output logic [7:0]          bData_Hdr_out_IPProtocol,
    output logic [31:0]         bData_Hdr_out_IPSrcIpAddr,
    output logic [31:0]         bData_Hdr_out_IPDstIpAddr,
    output logic [15:0]         bData_Hdr_out_UDPSrcPort,
    output logic [15:0]         bData_Hdr_out_UDPDstPort,
    output logic [15:0]         bData_Hdr_out_UDPLength,
    output logic [15:0]         bData_Hdr_out_UDPCheckSum,
    output logic                wData_out_valid,
    input  logic                wData_out_ready,
    output logic [DATA_W-1:0]   bData_out_data,
    output logic [DATA_W/8-1:0] bData_out_keep,
    output logic                wData_out_last,
    output logic [31:0]         bEarlyTerminate_packet_cnt
);
    localparam int KEEP_W = DATA_W / 8;
    localparam int HALF_W = DATA_W / 2;
    localparam int HALF_K = KEEP_W / 2;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] UDP_HDR  = 3'd1;
    localparam logic [2:0] PAYLOAD  = 3'd2;
    localparam logic [2:0] FLUSH    = 3'd3;
    localparam logic [2:0] WAIT_HDR = 3'd4;

    typedef struct packed {
        logic [47:0] macDst;
        logic [47:0] macSrc;
        logic [15:0] frameType;
        logic [3:0]  ipVersion;
        logic [3:0]  ipIhl;
        logic [5:0]  ipDscp;
        logic [1:0]  ipEcn;
        logic [15:0] ipLength;
        logic [15:0] ipId;
        logic [15:0] ipCheckSum;
        logic [2:0]  ipFlag;
        logic [12:0] ipFragOffset;
        logic [7:0]  ipTtl;
        logic [7:0]  ipProtocol;
        logic [31:0] ipSrc;
        logic [31:0] ipDst;
    } ipHdr_t;

    logic [2:0]        state;
    ipHdr_t            hdrIn, hdrQ;
    logic [HALF_W-1:0] residue;
    logic [HALF_K-1:0] residueKeep;
    logic              canLoad;
    logic              inFire;

    assign hdrIn = '{bData_Hdr_in_MacDstMacAddr, bData_Hdr_in_MacSrcMacAddr,
                     bData_Hdr_in_MacFrameType, bData_Hdr_in_IPVersion, bData_Hdr_in_IPIhl,
                     bData_Hdr_in_IPDscp, bData_Hdr_in_IPEcn, bData_Hdr_in_IPLength,
                     bData_Hdr_in_IPIdentification, bData_Hdr_in_IPCheckSum, bData_Hdr_in_IPFlag,
                     bData_Hdr_in_IPFragOffset, bData_Hdr_in_IPTimeToLive, bData_Hdr_in_IPProtocol,
                     bData_Hdr_in_IPSrcIpAddr, bData_Hdr_in_IPDstIpAddr};

    assign bData_Hdr_out_MacDstMacAddr    = hdrQ.macDst;
    assign bData_Hdr_out_MacSrcMacAddr    = hdrQ.macSrc;
    assign bData_Hdr_out_MacFrameType     = hdrQ.frameType;
    assign bData_Hdr_out_IPVersion        = hdrQ.ipVersion;
    assign bData_Hdr_out_IPIhl            = hdrQ.ipIhl;
    assign bData_Hdr_out_IPDscp           = hdrQ.ipDscp;
    assign bData_Hdr_out_IPEcn            = hdrQ.ipEcn;
    assign bData_Hdr_out_IPLength         = hdrQ.ipLength;
    assign bData_Hdr_out_IPIdentification = hdrQ.ipId;
    assign bData_Hdr_out_IPCheckSum       = hdrQ.ipCheckSum;
    assign bData_Hdr_out_IPFlag           = hdrQ.ipFlag;
    assign bData_Hdr_out_IPFragOffset     = hdrQ.ipFragOffset;
    assign bData_Hdr_out_IPTimeToLive     = hdrQ.ipTtl;
    assign bData_Hdr_out_IPProtocol       = hdrQ.ipProtocol;
    assign bData_Hdr_out_IPSrcIpAddr      = hdrQ.ipSrc;
    assign bData_Hdr_out_IPDstIpAddr      = hdrQ.ipDst;

    // Output register may load when empty or draining this cycle.
    assign canLoad = !wData_out_valid || wData_out_ready;
    assign inFire  = wData_in_valid && wData_in_ready;

    always_comb begin
        wData_Hdr_in_ready = wRst && (state == IDLE);
        wData_in_ready     = 1'b0;
        case (state)
            UDP_HDR: wData_in_ready = wRst;
            PAYLOAD: wData_in_ready = wRst && canLoad;
            default: wData_in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge wClk or negedge wRst) begin
        if (!wRst) begin
            state                      <= IDLE;
            hdrQ                       <= '0;
            residue                    <= '0;
            residueKeep                <= '0;
            wData_Hdr_out_valid        <= 1'b0;
            bData_Hdr_out_UDPSrcPort   <= '0;
            bData_Hdr_out_UDPDstPort   <= '0;
            bData_Hdr_out_UDPLength    <= '0;
            bData_Hdr_out_UDPCheckSum  <= '0;
            wData_out_valid            <= 1'b0;
            bData_out_data             <= '0;
            bData_out_keep             <= '0;
            wData_out_last             <= 1'b0;
            bEarlyTerminate_packet_cnt <= '0;
        end else begin
            if (wData_Hdr_out_valid && wData_Hdr_out_ready) wData_Hdr_out_valid <= 1'b0;
            if (wData_out_valid && wData_out_ready)         wData_out_valid     <= 1'b0;
            case (state)
                IDLE: begin
                    if (wData_Hdr_in_valid) begin
                        hdrQ  <= hdrIn;
                        state <= UDP_HDR;
                    end
                end
                UDP_HDR: begin
                    if (inFire) begin
                        if (wData_in_last && !bData_in_keep[HALF_K-1]) begin
                            // Truncated before the UDP header completed: drop silently.
                            bEarlyTerminate_packet_cnt <= bEarlyTerminate_packet_cnt + 32'd1;
                            state                      <= IDLE;
                        end else begin
                            bData_Hdr_out_UDPSrcPort  <= {bData_in_data[7:0],   bData_in_data[15:8]};
                            bData_Hdr_out_UDPDstPort  <= {bData_in_data[23:16], bData_in_data[31:24]};
                            bData_Hdr_out_UDPLength   <= {bData_in_data[39:32], bData_in_data[47:40]};
                            bData_Hdr_out_UDPCheckSum <= {bData_in_data[55:48], bData_in_data[63:56]};
                            residue                   <= bData_in_data[DATA_W-1:HALF_W];
                            residueKeep               <= bData_in_keep[KEEP_W-1:HALF_K];
                            wData_Hdr_out_valid       <= 1'b1;
                            if (wData_in_last && !bData_in_keep[HALF_K]) begin
                                wData_out_valid <= 1'b1;
                                bData_out_data  <= '0;
                                bData_out_keep  <= '0;
                                wData_out_last  <= 1'b1;
                                state           <= WAIT_HDR;
                            end else if (wData_in_last) begin
                                state <= FLUSH;
                            end else begin
                                state <= PAYLOAD;
                            end
                        end
                    end
                end
                PAYLOAD: begin
                    if (inFire) begin
                        wData_out_valid <= 1'b1;
                        bData_out_data  <= {bData_in_data[HALF_W-1:0], residue};
                        bData_out_keep  <= {bData_in_keep[HALF_K-1:0], residueKeep};
                        wData_out_last  <= wData_in_last && !bData_in_keep[HALF_K];
                        residue         <= bData_in_data[DATA_W-1:HALF_W];
                        residueKeep     <= bData_in_keep[KEEP_W-1:HALF_K];
                        if (wData_in_last) state <= bData_in_keep[HALF_K] ? FLUSH : WAIT_HDR;
                    end
                end
                FLUSH: begin
                    if (canLoad) begin
                        wData_out_valid <= 1'b1;
                        bData_out_data  <= {{HALF_W{1'b0}}, residue};
                        bData_out_keep  <= {{HALF_K{1'b0}}, residueKeep};
                        wData_out_last  <= 1'b1;
                        state           <= WAIT_HDR;
                    end
                end
                WAIT_HDR: begin
                    if ((!wData_Hdr_out_valid || wData_Hdr_out_ready) &&
                        (!wData_out_valid || wData_out_ready))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_udp_rx_parser.sv
// Scoreboard bench for udp_rx_parser: directed packets push expected header and
// payload beats; a negedge monitor pops and compares on each output handshake.
module tb_udp_rx_parser;
    typedef struct packed {
        logic [47:0] macDst;
        logic [47:0] macSrc;
        logic [15:0] frameType;
        logic [3:0]  ipVer;
        logic [3:0]  ipIhl;
        logic [5:0]  ipDscp;
        logic [1:0]  ipEcn;
        logic [15:0] ipLen;
        logic [15:0] ipId;
        logic [15:0] ipCs;
        logic [2:0]  ipFlag;
        logic [12:0] ipFrag;
        logic [7:0]  ipTtl;
        logic [7:0]  ipProto;
        logic [31:0] ipSrc;
        logic [31:0] ipDst;
    } hdr_t;

    logic         wClk = 1'b0;
    logic         wRst;
    logic         hdrInValid, hdrInReady;
    hdr_t         hdrDrv;
    logic         inValid, inReady, inLast;
    logic [127:0] inData;
    logic [15:0]  inKeep;
    logic         hdrOutValid, hdrOutReady;
    logic         outValid, outReady, outLast;
    logic [127:0] outData;
    logic [15:0]  outKeep;
    logic [31:0]  cnt;
    logic [47:0]  oMacDst, oMacSrc;
    logic [15:0]  oFrameType, oIpLen, oIpId, oIpCs, oUdpSrc, oUdpDst, oUdpLen, oUdpCs;
    logic [3:0]   oIpVer, oIpIhl;
    logic [5:0]   oIpDscp;
    logic [1:0]   oIpEcn;
    logic [2:0]   oIpFlag;
    logic [12:0]  oIpFrag;
    logic [7:0]   oIpTtl, oIpProto;
    logic [31:0]  oIpSrc, oIpDst;

    int  nCmp = 0;
    int  nErr = 0;
    bit  monEn = 1'b1;
    bit  togEn = 1'b0;
    bit  outReadyMain = 1'b1;

    logic [335:0] hdrAct;
    logic [144:0] payAct;
    logic [335:0] hdrExpQ[$];
    logic [144:0] payExpQ[$];

    assign hdrAct = {oMacDst, oMacSrc, oFrameType, oIpVer, oIpIhl, oIpDscp, oIpEcn, oIpLen,
                     oIpId, oIpCs, oIpFlag, oIpFrag, oIpTtl, oIpProto, oIpSrc, oIpDst,
                     oUdpSrc, oUdpDst, oUdpLen, oUdpCs};
    assign payAct = {outData, outKeep, outLast};

    udp_rx_parser #(.DATA_W(128)) dut (
        .wClk(wClk), .wRst(wRst),
        .wData_Hdr_in_valid(hdrInValid), .wData_Hdr_in_ready(hdrInReady),
        .bData_Hdr_in_MacDstMacAddr(hdrDrv.macDst), .bData_Hdr_in_MacSrcMacAddr(hdrDrv.macSrc),
        .bData_Hdr_in_MacFrameType(hdrDrv.frameType), .bData_Hdr_in_IPVersion(hdrDrv.ipVer),
        .bData_Hdr_in_IPIhl(hdrDrv.ipIhl), .bData_Hdr_in_IPDscp(hdrDrv.ipDscp),
        .bData_Hdr_in_IPEcn(hdrDrv.ipEcn), .bData_Hdr_in_IPLength(hdrDrv.ipLen),
        .bData_Hdr_in_IPIdentification(hdrDrv.ipId), .bData_Hdr_in_IPCheckSum(hdrDrv.ipCs),
        .bData_Hdr_in_IPFlag(hdrDrv.ipFlag), .bData_Hdr_in_IPFragOffset(hdrDrv.ipFrag),
        .bData_Hdr_in_IPTimeToLive(hdrDrv.ipTtl), .bData_Hdr_in_IPProtocol(hdrDrv.ipProto),
        .bData_Hdr_in_IPSrcIpAddr(hdrDrv.ipSrc), .bData_Hdr_in_IPDstIpAddr(hdrDrv.ipDst),
        .wData_in_valid(inValid), .wData_in_ready(inReady),
        .bData_in_data(inData), .bData_in_keep(inKeep), .wData_in_last(inLast),
        .wData_Hdr_out_valid(hdrOutValid), .wData_Hdr_out_ready(hdrOutReady),
        .bData_Hdr_out_MacDstMacAddr(oMacDst), .bData_Hdr_out_MacSrcMacAddr(oMacSrc),
        .bData_Hdr_out_MacFrameType(oFrameType), .bData_Hdr_out_IPVersion(oIpVer),
        .bData_Hdr_out_IPIhl(oIpIhl), .bData_Hdr_out_IPDscp(oIpDscp),
        .bData_Hdr_out_IPEcn(oIpEcn), .bData_Hdr_out_IPLength(oIpLen),
        .bData_Hdr_out_IPIdentification(oIpId), .bData_Hdr_out_IPCheckSum(oIpCs),
        .bData_Hdr_out_IPFlag(oIpFlag), .bData_Hdr_out_IPFragOffset(oIpFrag),
        .bData_Hdr_out_IPTimeToLive(oIpTtl), .bData_Hdr_out_IPProtocol(oIpProto),
        .bData_Hdr_out_IPSrcIpAddr(oIpSrc), .bData_Hdr_out_IPDstIpAddr(oIpDst),
        .bData_Hdr_out_UDPSrcPort(oUdpSrc), .bData_Hdr_out_UDPDstPort(oUdpDst),
        .bData_Hdr_out_UDPLength(oUdpLen), .bData_Hdr_out_UDPCheckSum(oUdpCs),
        .wData_out_valid(outValid), .wData_out_ready(outReady),
        .bData_out_data(outData), .bData_out_keep(outKeep), .wData_out_last(outLast),
        .bEarlyTerminate_packet_cnt(cnt)
    );

    always #5 wClk = ~wClk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic flagFail(input string name, input string why);
        nCmp++;
        nErr++;
        $display("FAIL %s: %s", name, why);
    endtask

    function automatic hdr_t mkHdr(input int b);
        hdr_t h;
        h.macDst = 48'(b);      h.macSrc = 48'(b + 1);   h.frameType = 16'(b + 2);
        h.ipVer  = 4'(b + 3);   h.ipIhl  = 4'(b + 4);    h.ipDscp    = 6'(b + 5);
        h.ipEcn  = 2'(b + 6);   h.ipLen  = 16'(b + 7);   h.ipId      = 16'(b + 8);
        h.ipCs   = 16'(b + 9);  h.ipFlag = 3'(b + 10);   h.ipFrag    = 13'(b + 11);
        h.ipTtl  = 8'(b + 12);  h.ipProto = 8'(b + 13);  h.ipSrc     = 32'(b + 14);
        h.ipDst  = 32'(b + 15);
        return h;
    endfunction

    // All drivers start and end at posedge+1 so inputs are stable across the next edge.
    task automatic sendHdr(input hdr_t h);
        int n = 0;
        hdrDrv = h;
        hdrInValid = 1'b1;
        @(negedge wClk);
        while (!hdrInReady && n < 200) begin n++; @(negedge wClk); end
        if (!hdrInReady) flagFail("hdr_in_accept", "timed out waiting for header ready");
        @(posedge wClk); #1;
        hdrInValid = 1'b0;
    endtask

    task automatic sendBeat(input logic [127:0] d, input logic [15:0] k, input logic l);
        int n = 0;
        inData = d; inKeep = k; inLast = l;
        inValid = 1'b1;
        @(negedge wClk);
        while (!inReady && n < 200) begin n++; @(negedge wClk); end
        if (!inReady) flagFail("data_in_accept", "timed out waiting for data ready");
        @(posedge wClk); #1;
        inValid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((hdrExpQ.size() != 0 || payExpQ.size() != 0) && n < 500) begin
            n++; @(posedge wClk);
        end
        if (hdrExpQ.size() != 0 || payExpQ.size() != 0) flagFail(name, "expected outputs never appeared");
        repeat (3) @(posedge wClk);
        #1;
    endtask

    initial begin : toggler
        outReady = 1'b1;
        forever begin
            @(posedge wClk); #1;
            outReady = togEn ? ~outReady : outReadyMain;
        end
    end

    initial begin : monitor
        logic [335:0] hdrHeld, hdrExp;
        logic [144:0] payHeld, payExp;
        bit hdrStall, payStall;
        hdrStall = 1'b0; payStall = 1'b0; hdrHeld = '0; payHeld = '0;
        forever begin
            @(negedge wClk);
            if (!monEn) begin
                hdrStall = 1'b0; payStall = 1'b0;
            end else begin
                if (hdrOutValid) begin
                    if (hdrStall) chk("hdr_stable", 512'(hdrAct), 512'(hdrHeld));
                    if (hdrOutReady) begin
                        if (hdrExpQ.size() == 0) flagFail("hdr_extra", $sformatf("unexpected header %0h", hdrAct));
                        else begin hdrExp = hdrExpQ.pop_front(); chk("hdr_out", 512'(hdrAct), 512'(hdrExp)); end
                        hdrStall = 1'b0;
                    end else begin
                        hdrStall = 1'b1; hdrHeld = hdrAct;
                    end
                end else hdrStall = 1'b0;
                if (outValid) begin
                    if (payStall) chk("pay_stable", 512'(payAct), 512'(payHeld));
                    if (outReady) begin
                        if (payExpQ.size() == 0) flagFail("pay_extra", $sformatf("unexpected beat %0h", payAct));
                        else begin payExp = payExpQ.pop_front(); chk("pay_out", 512'(payAct), 512'(payExp)); end
                        payStall = 1'b0;
                    end else begin
                        payStall = 1'b1; payHeld = payAct;
                    end
                end else payStall = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        hdr_t h;
        wRst = 1'b0; hdrInValid = 1'b0; inValid = 1'b0; inData = '0; inKeep = '0; inLast = 1'b0;
        hdrDrv = mkHdr(100); hdrOutReady = 1'b1;
        #12;
        chk("rst_hdr_fields", 512'(hdrAct), 512'(0));
        chk("rst_ctl", 512'({hdrOutValid, outValid, hdrInReady, inReady, payAct, cnt}), 512'(0));
        @(negedge wClk); wRst = 1'b1;
        @(posedge wClk); #1;

        // 4-beat packet, last beat full so a flush beat carries the residue.
        h = mkHdr(1);
        hdrExpQ.push_back({h, 16'h3412, 16'h0000, 16'h0000, 16'h0000});
        payExpQ.push_back({64'h5678, 64'h0, 16'hffff, 1'b0});
        payExpQ.push_back({64'h9abc, 64'h0, 16'hffff, 1'b0});
        payExpQ.push_back({64'hdef0, 64'h0, 16'hffff, 1'b0});
        payExpQ.push_back({128'h0, 16'h00ff, 1'b1});
        sendHdr(h);
        sendBeat(128'h1234, 16'hffff, 1'b0);
        sendBeat(128'h5678, 16'hffff, 1'b0);
        sendBeat(128'h9abc, 16'hffff, 1'b0);
        sendBeat(128'hdef0, 16'hffff, 1'b1);
        drain("pkt_basic");

        // Truncated: 6 bytes only.
        sendHdr(mkHdr(32));
        sendBeat(128'h00ff_eedd_ccbb_aa99_8877_6655_4433_2211, 16'h003f, 1'b1);
        repeat (3) @(posedge wClk);
        #1;
        chk("cnt_early", 512'(cnt), 512'(1));
        drain("pkt_early");

        // Exactly the 8-byte UDP header.
        h = mkHdr(48);
        hdrExpQ.push_back({h, 16'h0102, 16'h0304, 16'h0506, 16'h0708});
        payExpQ.push_back({128'h0, 16'h0000, 1'b1});
        sendHdr(h);
        sendBeat({64'hffff_ffff_ffff_ffff, 64'h0807_0605_0403_0201}, 16'h00ff, 1'b1);
        drain("pkt_hdr_only");

        // Second beat of 8 bytes folds into one full output beat, no flush.
        h = mkHdr(56);
        hdrExpQ.push_back({h, 16'h1122, 16'h3344, 16'h5566, 16'h7788});
        payExpQ.push_back({64'hdddd_dddd_dddd_dddd, 64'hcccc_cccc_cccc_cccc, 16'hffff, 1'b1});
        sendHdr(h);
        sendBeat({64'hcccc_cccc_cccc_cccc, 64'h8877_6655_4433_2211}, 16'hffff, 1'b0);
        sendBeat({64'h0, 64'hdddd_dddd_dddd_dddd}, 16'h00ff, 1'b1);
        drain("pkt_two_beat");

        // Output ready toggling every cycle; last beat of 12 bytes leaves 4 for flush.
        togEn = 1'b1;
        h = mkHdr(64);
        hdrExpQ.push_back({h, 64'h0});
        payExpQ.push_back({64'hb1, 64'ha0, 16'hffff, 1'b0});
        payExpQ.push_back({64'hb2, 64'ha1, 16'hffff, 1'b0});
        payExpQ.push_back({64'hb3, 64'ha2, 16'hffff, 1'b0});
        payExpQ.push_back({64'h0, 64'ha3, 16'h000f, 1'b1});
        sendHdr(h);
        sendBeat({64'ha0, 64'h0}, 16'hffff, 1'b0);
        sendBeat({64'ha1, 64'hb1}, 16'hffff, 1'b0);
        sendBeat({64'ha2, 64'hb2}, 16'hffff, 1'b0);
        sendBeat({64'ha3, 64'hb3}, 16'h0fff, 1'b1);
        drain("pkt_toggle");
        togEn = 1'b0;
        repeat (2) @(posedge wClk);
        #1;

        // Header-out stalled: next header must wait for the handshake.
        hdrOutReady = 1'b0;
        h = mkHdr(80);
        hdrExpQ.push_back({h, 16'h0004, 16'h0003, 16'h0002, 16'h0001});
        payExpQ.push_back({128'h0, 16'h0000, 1'b1});
        sendHdr(h);
        sendBeat({64'h0, 64'h0100_0200_0300_0400}, 16'h00ff, 1'b1);
        h = mkHdr(96);
        hdrDrv = h;
        hdrInValid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge wClk);
            chk("hdr_in_blocked", 512'(hdrInReady), 512'(0));
        end
        chk("hdr_out_held", 512'(hdrOutValid), 512'(1));
        @(posedge wClk); #1;
        hdrOutReady = 1'b1;
        hdrExpQ.push_back({h, 16'h0102, 16'h0304, 16'h0506, 16'h0708});
        payExpQ.push_back({128'h0, 16'h0000, 1'b1});
        sendHdr(h);
        sendBeat({64'h0, 64'h0807_0605_0403_0201}, 16'h00ff, 1'b1);
        drain("pkt_hdr_stall");
        chk("cnt_hold", 512'(cnt), 512'(1));

        // Reset mid-payload with outputs pending.
        monEn = 1'b0;
        hdrOutReady = 1'b0;
        outReadyMain = 1'b0;
        repeat (2) @(posedge wClk);
        #1;
        sendHdr(mkHdr(112));
        sendBeat({64'h5555, 64'h4444}, 16'hffff, 1'b0);
        sendBeat({64'h7777, 64'h6666}, 16'hffff, 1'b0);
        wRst = 1'b0;
        #1;
        chk("midrst_hdr_fields", 512'(hdrAct), 512'(0));
        chk("midrst_ctl", 512'({hdrOutValid, outValid, hdrInReady, inReady, payAct, cnt}), 512'(0));
        @(negedge wClk);
        wRst = 1'b1;
        hdrOutReady = 1'b1;
        outReadyMain = 1'b1;
        monEn = 1'b1;
        repeat (2) @(posedge wClk);
        #1;

        // Clean packet after reset.
        h = mkHdr(1);
        hdrExpQ.push_back({h, 16'h3412, 48'h0});
        payExpQ.push_back({64'h5678, 64'h0, 16'hffff, 1'b0});
        payExpQ.push_back({64'h9abc, 64'h0, 16'hffff, 1'b0});
        payExpQ.push_back({64'hdef0, 64'h0, 16'hffff, 1'b0});
        payExpQ.push_back({128'h0, 16'h00ff, 1'b1});
        sendHdr(h);
        sendBeat(128'h1234, 16'hffff, 1'b0);
        sendBeat(128'h5678, 16'hffff, 1'b0);
        sendBeat(128'h9abc, 16'hffff, 1'b0);
        sendBeat(128'hdef0, 16'hffff, 1'b1);
        drain("pkt_after_rst");
        chk("cnt_after_rst", 512'(cnt), 512'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
